// File: rtl/boot_image_loader.sv
// Loads N_IMAGES word images from the SPI-flash word stream into separate RAM banks, then releases SoC reset.
// Optional per-image checksum trailer: define BOOT_LOADER_CKSUM_EN.
module boot_image_loader #(
    parameter int                       N_IMAGES   = 2,
    parameter int                       ADDR_W     = 14,
    parameter int                       MIN_WORDS  = 1024,
    parameter int                       MAX_WORDS  = 16384,
    parameter logic [31:0]              TERM_WORD  = 32'hFFFF_FFFF,
    parameter int                       GAP_CYCLES = 13,
    parameter logic [N_IMAGES*24-1:0]   FLASH_BASE = {24'h050000, 24'h030000}
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        word_valid_i,
    input  logic [31:0]                 word_i,
    input  logic                        hw_done_i,
    output logic                        fill_o,
    output logic                        fifo_rst_o,
    output logic [23:0]                 flash_addr_o,
    output logic [N_IMAGES-1:0]         mem_sel_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    output logic                        mem_we_o,
    output logic [$clog2(N_IMAGES):0]   img_idx_o,
    output logic [N_IMAGES-1:0]         err_o,
    output logic                        boot_done_o,
    output logic                        soc_rst_o
);

    localparam int IMG_W = $clog2(N_IMAGES) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [ADDR_W:0]   MIN_C    = (ADDR_W + 1)'(MIN_WORDS);
    localparam logic [ADDR_W-1:0] MAX_LAST = ADDR_W'(MAX_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IMG_W-1:0]  IMG_LAST = IMG_W'(N_IMAGES - 1);

`ifdef BOOT_LOADER_CKSUM_EN
    typedef enum logic [1:0] {LOAD, CKSUM, GAP, DONE} state_t;
`else
    typedef enum logic [1:0] {LOAD, GAP, DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [IMG_W-1:0]    img_q, img_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [N_IMAGES-1:0] err_q, err_d;
    logic                fill_q;
    logic [N_IMAGES-1:0] img_bit;
    logic                is_term;
`ifdef BOOT_LOADER_CKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    assign img_bit = N_IMAGES'(1) << img_q;
    // A terminator only counts once the minimum image size is already written.
    assign is_term = (word_i == TERM_WORD) && ({1'b0, wr_cnt_q} >= MIN_C);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= LOAD;
            img_q     <= '0;
            wr_cnt_q  <= '0;
            gap_cnt_q <= '0;
            err_q     <= '0;
            fill_q    <= 1'b0;
`ifdef BOOT_LOADER_CKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            img_q     <= img_d;
            wr_cnt_q  <= wr_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_q     <= err_d;
`ifdef BOOT_LOADER_CKSUM_EN
            fill_q    <= (state_q == LOAD) || (state_q == CKSUM);
            sum_q     <= sum_d;
`else
            fill_q    <= (state_q == LOAD);
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d   = state_q;
        img_d     = img_q;
        wr_cnt_d  = wr_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = err_q;
`ifdef BOOT_LOADER_CKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            LOAD: begin
                if (word_valid_i) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (is_term) begin
`ifdef BOOT_LOADER_CKSUM_EN
                        state_d = CKSUM;
`else
                        state_d = GAP;
`endif
                    end else begin
`ifdef BOOT_LOADER_CKSUM_EN
                        sum_d = sum_q + word_i;
`endif
                        if (wr_cnt_q == MAX_LAST) begin
                            err_d   = err_q | img_bit;
                            state_d = GAP;
                        end
                    end
                end
            end
`ifdef BOOT_LOADER_CKSUM_EN
            CKSUM: begin
                if (word_valid_i) begin
                    if (word_i != sum_q) err_d = err_q | img_bit;
                    state_d = GAP;
                end
            end
`endif
            GAP: begin
                wr_cnt_d  = '0;
`ifdef BOOT_LOADER_CKSUM_EN
                sum_d     = '0;
`endif
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    img_d     = img_q + 1'b1;
                    state_d   = (img_q == IMG_LAST) ? DONE : LOAD;
                end
            end
            DONE: ;
            default: state_d = LOAD;
        endcase
    end

    // In DONE img has moved past the last bank; the flash address holds the last image's.
    always_comb begin
        flash_addr_o = FLASH_BASE[23:0];
        mem_sel_o    = '0;
        for (int i = 0; i < N_IMAGES; i++) begin
            if (img_q == IMG_W'(i) || (state_q == DONE && i == N_IMAGES - 1))
                flash_addr_o = FLASH_BASE[i*24 +: 24];
            if (state_q == LOAD && img_q == IMG_W'(i))
                mem_sel_o[i] = 1'b1;
        end
    end

    assign fill_o      = fill_q;
    assign fifo_rst_o  = rst_i | (state_q == GAP);
    assign mem_we_o    = word_valid_i & (state_q == LOAD);
    assign mem_addr_o  = wr_cnt_q;
    assign mem_wdata_o = word_i;
    assign img_idx_o   = img_q;
    assign err_o       = err_q;
    assign boot_done_o = (state_q == DONE) & hw_done_i;
    assign soc_rst_o   = ~boot_done_o;

endmodule

// File: doc/boot_image_loader.md
Name: boot_image_loader

Overview:
- Parametrised successor to the two-image SPRAM boot sequencer.
- After reset, loads N_IMAGES word images from SPI flash into N_IMAGES separate RAM banks, in order, through the existing SPI-flash word-stream FIFO.
- Each image ends at a terminator word once a minimum size has been reached, or at a hard maximum size.
- When all images are loaded and the hard-IP done flag is high, the block releases SoC reset and reports per-image errors.

Parameters:
- N_IMAGES, 2, number of images / RAM banks (1..8).
- ADDR_W, 14, RAM word-address width.
- MIN_WORDS, 1024, terminator ignored while fewer than this many words are already written.
- MAX_WORDS, 16384, hard image limit in words (<= 2**ADDR_W).
- TERM_WORD, 32'hFFFF_FFFF, end-of-image marker.
- GAP_CYCLES, 13, FIFO-reset cycles between images (>= 1).
- FLASH_BASE, {24'h050000,24'h030000}, packed N_IMAGES x 24-bit flash start addresses; image 0 is in the LSBs.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- word_valid_i  in  1  one stream word is present this cycle.
- word_i  in  32  stream word.
- hw_done_i  in  1  hard-IP configuration done.
- fill_o  out  1  request stream fill from the FIFO.
- fifo_rst_o  out  1  active-high FIFO/stream reset.
- flash_addr_o  out  24  flash start address of the current image.
- mem_sel_o  out  N_IMAGES  one-hot bank select.
- mem_addr_o  out  ADDR_W  write address.
- mem_wdata_o  out  32  write data (equals word_i).
- mem_we_o  out  1  write strobe.
- img_idx_o  out  clog2(N_IMAGES)+1  index of the image being loaded.
- err_o  out  N_IMAGES  sticky per-image error.
- boot_done_o  out  1  all images loaded and hw_done_i high.
- soc_rst_o  out  1  equals ~boot_done_o.

Behaviour:
- States: LOAD, CKSUM (only with the optional feature), GAP, DONE.
- Reset values: state=LOAD, img=0, wr_cnt=0, gap_cnt=0, fill_o=0, err_o=0. During reset: fifo_rst_o=1, boot_done_o=0, soc_rst_o=1.
- fill_o is registered: it is 1 one cycle after any clock edge in state LOAD or CKSUM, and 0 otherwise.
- fifo_rst_o = rst_i | (state==GAP).
- flash_addr_o = FLASH_BASE[img*24 +: 24]. In DONE it holds the last image's address.
- mem_we_o = word_valid_i & (state==LOAD); it is combinational, with zero latency from the word.
- mem_addr_o = wr_cnt.
- mem_sel_o = onehot(img) in LOAD; 0 in every other state.
- LOAD, on word_valid_i:
  - The word is written and wr_cnt increments.
  - If word_i==TERM_WORD and wr_cnt (before increment) >= MIN_WORDS: go to GAP, or to CKSUM when the feature is enabled.
  - A TERM_WORD seen while wr_cnt < MIN_WORDS is ordinary data.
  - If a non-terminating word is written at wr_cnt==MAX_WORDS-1: set err_o[img] and go to GAP.
- GAP:
  - Lasts exactly GAP_CYCLES cycles; wr_cnt is cleared; word_valid_i is ignored.
  - On exit, img increments. If img was N_IMAGES-1, go to DONE; otherwise go to LOAD.
- DONE: terminal state; word_valid_i is ignored. boot_done_o = hw_done_i (combinational). If hw_done_i falls, boot_done_o falls as well.
- Simultaneous events: the terminator check takes precedence over the MAX check on the same word.
- Assertion of rst_i in any state immediately aborts the load and restarts at image 0. err_o is cleared.

Optional Feature:
- Macro: BOOT_LOADER_CKSUM_EN.
- Enabled:
  - A 32-bit modular sum accumulates every written word except the terminator; the sum is cleared on entry to each image.
  - After the terminator, CKSUM waits for the next valid word. That word is not written (mem_we_o=0).
  - If the word != sum, err_o[img] is set. Either way the state then moves to GAP.
  - MAX overflow skips CKSUM.
- Disabled: there is no CKSUM state and no accumulator; the terminator goes directly to GAP.

Test Plan:
- Bench parameters: N_IMAGES=2, MIN_WORDS=4, MAX_WORDS=16, GAP_CYCLES=3.
- Two normal images: img0 words 1,2,3,4,FFFFFFFF -> bank0 addrs 0..4 written with mem_sel_o=01; fifo_rst_o high for exactly 3 cycles; flash_addr_o changes 030000 -> 050000. img1 words 5,6,7,8,FFFFFFFF -> bank1 addrs 0..4 written, DONE reached; boot_done_o=0 until hw_done_i=1, then 1 in the same cycle, and soc_rst_o=0.
- Early terminator: img0 stream FFFFFFFF,A,B,C,D,FFFFFFFF -> the first FFFFFFFF is written at addr 0 as data; six writes in total; the terminator is accepted at addr 5.
- Overflow: 16 words of 0x11 with no terminator -> the write at addr 15 sets err_o[0]=1 and the block enters GAP; img1 then loads normally, and err_o stays 2'b01.
- Reset mid-load: rst_i pulsed after 3 words of img1 -> fifo_rst_o=1, fill_o=0, img_idx_o=0, err_o=0 during reset; the load restarts at image 0, addr 0.
- BOOT_LOADER_CKSUM_EN: img0 words 1,2,3,4,FFFFFFFF,0000000A -> the checksum word is not written and err_o[0]=0. Repeat with a checksum word of 0000000B -> err_o[0]=1.
